mac_dot_seq: RTL and testbench
==============================

Name: mac_dot_seq

Overview:
Dot-product sequencer directly upstream of the 16-bit MAC (36-bit accumulator). It accepts a vector length and a stream of 16-bit operand pairs over a valid/ready handshake. It drives the MAC's operands and reset, then captures the final accumulator value as a dot-product result with its own valid/ready handshake.

Parameters:
LEN_W, 8, width of vector-length input; max vector length 2^LEN_W-1
MAC_LAT, 1, clk cycles from an operand pair appearing on mac_a/mac_b to its product being reflected in mac_out

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a dot product; sampled in IDLE only
len  input  LEN_W  vector length, latched when start is accepted
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer accepts a pair this cycle
a_in  input  16  operand A, unsigned
b_in  input  16  operand B, unsigned
mac_a  output  16  registered operand A to MAC
mac_b  output  16  registered operand B to MAC
mac_reset  output  1  registered clear for MAC accumulator
mac_out  input  36  MAC accumulator value
result  output  36  captured dot product
result_valid  output  1  result held valid
result_ready  input  1  consumer accepts result
busy  output  1  high in any state except IDLE

Behaviour:
- Async reset: state=IDLE, mac_reset=1, mac_a=mac_b=0, in_ready=0, result=0, result_valid=0, busy=0, counters=0.
- All outputs are registered except in_ready, which is a decode of state (STREAM only).
- IDLE: mac_reset=1, operands 0.
  - start=1, len>0: latch len, clear beat count, go to STREAM.
  - start=1, len=0: result<=0, go to DONE.
- STREAM: mac_reset=0, in_ready=1.
  - Beat accepted (in_valid&&in_ready): next cycle mac_a/mac_b=a_in/b_in; count+1.
  - No beat: next cycle mac_a/mac_b=0, so stalls add zero.
  - When the accepted beat makes count==len: go to DRAIN. in_ready drops the following cycle; no extra beat is accepted.
- DRAIN: operands 0, in_ready=0. Wait exactly MAC_LAT+1 cycles, which covers the operand register plus MAC latency. Then result<=mac_out, go to DONE.
- DONE: result_valid=1, result stable, mac_reset=1.
  - result_ready=1: result_valid<=0 next cycle, go to IDLE.
  - result is retained (not cleared) until the next capture.
- start outside IDLE: ignored. It is not queued.
- Back-to-back: start in the first IDLE cycle after DONE is honoured. Minimum gap between results is len+MAC_LAT+3 cycles.
- Reset mid-operation: the async reset returns to the reset values immediately. The partial sum is discarded and the MAC is cleared via mac_reset=1.
- Arithmetic: no arithmetic in the base block. Accumulation belongs to the MAC, and the 36-bit width wraps modulo 2^36 there.

Optional Feature:
MAC_DOT_SEQ_OVF_EN
- Defined:
  - Adds output ovf (1 bit, reset 0).
  - Keeps a shadow sum of accepted products, width 32+LEN_W, cleared on start.
  - At capture, ovf<=1 if the shadow sum > 2^36-1; it is valid alongside result.
  - result remains mac_out (wrapped).
- Undefined: no ovf port and no shadow logic.

Decomposition:
- Shared package mac_pkg:
  - OPW=16, ACCW=36.
  - FSM state enum {IDLE, STREAM, DRAIN, DONE}.
- One natural sub-module: mac_dot_seq_fsm (state register, beat/drain counters, next-state decode).
- The datapath registers stay in the top.

Test Plan:
- Dot product, no stalls: reset, then start, len=3, pairs (1,2),(5,2),(15,10) back-to-back, result_ready=1 -> result_valid with result=162 after DRAIN.
- Stalls: same pairs with in_valid low 2 cycles between beats -> result=162; mac_a/mac_b=0 during stalls.
- Zero length and result backpressure:
  - start with len=0 -> DONE, result=0, no MAC activity.
  - Hold result_ready=0 for 5 cycles -> result_valid and result stable, busy=1.
- Mid-stream reset: assert reset mid-stream after 2 of 3 beats -> all outputs at reset values immediately, mac_reset=1. A following len=1 (3,4) run -> result=12.
- Back-to-back runs, and start while busy: second start issued during STREAM is ignored. Run two sequential runs, len=2 (1,1),(2,2) then (7,7) with len=1 -> results 5 then 49.
- With MAC_DOT_SEQ_OVF_EN defined:
  - len=16 of (0xFFFF,0xFFFF) -> result=68717379600, ovf=0.
  - len=17 -> ovf=1, result=wrapped value modulo 2^36.

Source files
------------

// File: rtl/mac_pkg.sv
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared widths and FSM state encoding for the dot-product
//            sequencer that feeds the 16-bit MAC with a 36-bit accumulator.
// Contents : OPW   - operand width
//            ACCW  - accumulator / result width
//            state_t - sequencer state encoding (IDLE, STREAM, DRAIN, DONE)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int OPW  = 16;
    localparam int ACCW = 36;

    localparam int C_STATE_W = 2;

    typedef enum logic [C_STATE_W-1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_dot_seq_fsm.sv
// ============================================================================
// Module   : mac_dot_seq_fsm
// Purpose  : Control path of the dot-product sequencer: state register,
//            beat and drain counters, next-state decode and control strobes.
// Ports    : clk, reset         - clock, asynchronous active-high reset
//            i_start, i_len     - run request and vector length
//            i_in_valid         - operand pair offered
//            i_result_ready     - consumer accepts result
//            o_next_state       - state for the next cycle (drives the
//                                 registered outputs in the top)
//            o_in_ready         - STREAM decode
//            o_beat             - operand pair accepted this cycle
//            o_capture          - sample mac_out into result this cycle
//            o_zero_start       - zero-length run accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_dot_seq_fsm
    import mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_in_valid,
    input  logic             i_result_ready,
    output state_t           o_next_state,
    output logic             o_in_ready,
    output logic             o_beat,
    output logic             o_capture,
    output logic             o_zero_start
);

    // Drain counter must be able to hold MAC_LAT.
    localparam int C_DRAIN_W = $clog2(MAC_LAT + 2);
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_LAST = C_DRAIN_W'(MAC_LAT);

    state_t               r_state;
    state_t               w_next;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_count;
    logic [C_DRAIN_W-1:0] r_drain;
    logic                 w_last_beat;

    // State register and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_count <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_len   <= i_len;
                r_count <= '0;
            end else if (o_beat) begin
                r_count <= r_count + LEN_W'(1);
            end
            // Counts DRAIN cycles; resets whenever we are elsewhere.
            if (r_state == DRAIN) begin
                r_drain <= r_drain + C_DRAIN_W'(1);
            end else begin
                r_drain <= '0;
            end
        end
    end

    // r_len is never zero in STREAM, so len-1 cannot underflow there.
    assign w_last_beat = (r_count == (r_len - LEN_W'(1)));

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (i_len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (i_in_valid && w_last_beat) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain == C_DRAIN_LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (i_result_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Control strobes.
    always_comb begin
        o_next_state = w_next;
        o_in_ready   = (r_state == STREAM);
        o_beat       = (r_state == STREAM) && i_in_valid;
        // DRAIN lasts MAC_LAT+1 cycles: one for the operand register, then
        // the MAC latency, so the last product is visible in mac_out here.
        o_capture    = (r_state == DRAIN) && (r_drain == C_DRAIN_LAST);
        o_zero_start = (r_state == IDLE) && i_start && (i_len == '0);
    end

endmodule

`default_nettype wire

// File: rtl/mac_dot_seq.sv
// ============================================================================
// Module   : mac_dot_seq
// Purpose  : Dot-product sequencer upstream of a 16x16 MAC with a 36-bit
//            accumulator. Streams operand pairs into the MAC, then captures
//            the accumulator as the dot-product result.
// Ports    : clk, reset                 - clock, async active-high reset
//            start, len                 - run request, vector length
//            in_valid, in_ready         - operand handshake
//            a_in, b_in                 - unsigned operands
//            mac_a, mac_b, mac_reset    - registered MAC controls
//            mac_out                    - MAC accumulator value
//            result, result_valid,
//            result_ready               - result handshake
//            busy                       - not IDLE
//            ovf                        - (MAC_DOT_SEQ_OVF_EN only) true
//                                         sum exceeded 36 bits
// Config   : MAC_DOT_SEQ_OVF_EN adds the ovf output and a shadow sum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   a_in,
    input  logic [OPW-1:0]   b_in,
    output logic [OPW-1:0]   mac_a,
    output logic [OPW-1:0]   mac_b,
    output logic             mac_reset,
    input  logic [ACCW-1:0]  mac_out,
    output logic [ACCW-1:0]  result,
    output logic             result_valid,
    input  logic             result_ready,
`ifdef MAC_DOT_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    state_t w_next_state;
    logic   w_beat;
    logic   w_capture;
    logic   w_zero_start;

    mac_dot_seq_fsm #(
        .LEN_W   (LEN_W),
        .MAC_LAT (MAC_LAT)
    ) u_fsm (
        .clk            (clk),
        .reset          (reset),
        .i_start        (start),
        .i_len          (len),
        .i_in_valid     (in_valid),
        .i_result_ready (result_ready),
        .o_next_state   (w_next_state),
        .o_in_ready     (in_ready),
        .o_beat         (w_beat),
        .o_capture      (w_capture),
        .o_zero_start   (w_zero_start)
    );

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe. Idle cycles feed zero operands so
    // stalls contribute nothing to the accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_a        <= '0;
            mac_b        <= '0;
            mac_reset    <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            mac_a        <= w_beat ? a_in : '0;
            mac_b        <= w_beat ? b_in : '0;
            mac_reset    <= (w_next_state == IDLE) || (w_next_state == DONE);
            result_valid <= (w_next_state == DONE);
            busy         <= (w_next_state != IDLE);
            if (w_capture) begin
                result <= mac_out;
            end else if (w_zero_start) begin
                result <= '0;
            end
        end
    end

`ifdef MAC_DOT_SEQ_OVF_EN
    localparam int C_SHW  = 2 * OPW + LEN_W;
    localparam int C_CMPW = (C_SHW > ACCW) ? C_SHW : ACCW + 1;
    localparam logic [C_CMPW-1:0] C_ACC_MAX = C_CMPW'({ACCW{1'b1}});

    logic [C_SHW-1:0]   r_shadow;
    logic [2*OPW-1:0]   w_prod;
    logic [C_CMPW-1:0]  w_shadow_ext;

    assign w_prod       = {{OPW{1'b0}}, a_in} * {{OPW{1'b0}}, b_in};
    assign w_shadow_ext = C_CMPW'(r_shadow);

    // Exact sum of accepted products; held at zero while idle so every run
    // starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            ovf      <= 1'b0;
        end else begin
            if (!busy) begin
                r_shadow <= '0;
            end else if (w_beat) begin
                r_shadow <= r_shadow + C_SHW'(w_prod);
            end
            if (w_capture) begin
                ovf <= (w_shadow_ext > C_ACC_MAX);
            end else if (w_zero_start) begin
                ovf <= 1'b0;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_seq.sv
// ============================================================================
// Module   : tb_mac_dot_seq
// Purpose  : Self-checking bench for mac_dot_seq: table of dot-product runs
//            plus directed sequences for backpressure, mid-stream reset and
//            start-while-busy. A behavioural MAC (latency 1) closes the loop.
// Config   : MAC_DOT_SEQ_OVF_EN enables the overflow runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_dot_seq;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 1;

    typedef logic [3:0][15:0] ops_t;

    typedef struct {
        int          len;
        ops_t        a;
        ops_t        b;
        int          stall;
        logic [35:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      a_in = '0;
    logic [15:0]      b_in = '0;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_reset;
    logic [35:0]      mac_out;
    logic [35:0]      result;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic             busy;
`ifdef MAC_DOT_SEQ_OVF_EN
    logic             ovf;
`endif

    logic [35:0] acc = '0;
    int checks   = 0;
    int failures = 0;
    vec_t vecs[6];

    mac_dot_seq #(
        .LEN_W   (LEN_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_reset    (mac_reset),
        .mac_out      (mac_out),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
`ifdef MAC_DOT_SEQ_OVF_EN
        .ovf          (ovf),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: one-cycle latency from operands to accumulator.
    always @(posedge clk) begin
        if (mac_reset) acc <= '0;
        else           acc <= acc + ({20'd0, mac_a} * {20'd0, mac_b});
    end
    assign mac_out = acc;

    function automatic ops_t mk(input logic [15:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b);
        bit took;
        int guard;
        took  = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        while (!took && guard < 50) begin
            @(negedge clk);
            took = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        if (!took) check("beat_timeout", 64'd0, 64'd1);
        else       check("mac_ops_after_beat", {mac_a, mac_b}, {a, b});
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!result_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        if (!result_valid) check("result_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input string name, input int l, input ops_t a, input ops_t b,
                       input int stall, input logic [35:0] exp, input int exp_ovf);
        int cyc;
        start = 1'b1;
        len   = LEN_W'(l);
        tick();
        start = 1'b0;
        for (int i = 0; i < l; i++) begin
            send_beat(a[i % 4], b[i % 4]);
            if (i < l - 1) begin
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check({name, "_stall_ops_zero"}, {mac_a, mac_b}, 64'd0);
                end
            end
        end
        wait_result(cyc);
        check({name, "_drain_cycles"}, cyc, (l == 0) ? 0 : MAC_LAT + 1);
        check({name, "_result"}, result, exp);
        check({name, "_busy_done"}, busy, 1);
        check({name, "_mac_idle_done"}, {mac_reset, mac_a, mac_b}, {1'b1, 32'd0});
`ifdef MAC_DOT_SEQ_OVF_EN
        if (exp_ovf >= 0) check({name, "_ovf"}, ovf, exp_ovf[0]);
`else
        if (exp_ovf > 1) check({name, "_exp_ovf_arg"}, exp_ovf, 1);
`endif
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({name, "_valid_cleared"}, {result_valid, busy}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        bit  bp_ok;

        vecs[0] = '{3, mk(1, 5, 15, 0), mk(2, 2, 10, 0), 0, 36'd162};
        vecs[1] = '{3, mk(1, 5, 15, 0), mk(2, 2, 10, 0), 2, 36'd162};
        vecs[2] = '{0, mk(0, 0, 0, 0), mk(0, 0, 0, 0), 0, 36'd0};
        vecs[3] = '{2, mk(1, 2, 0, 0), mk(1, 2, 0, 0), 0, 36'd5};
        vecs[4] = '{1, mk(7, 0, 0, 0), mk(7, 0, 0, 0), 0, 36'd49};
        vecs[5] = '{4, mk(100, 0, 65535, 3), mk(200, 5, 1, 3), 1, 36'd85544};

        // Asynchronous reset takes effect without a clock edge.
        #1 reset = 1'b1;
        #1;
        check("reset_mac", {mac_reset, mac_a, mac_b}, {1'b1, 32'd0});
        check("reset_handshake", {in_ready, result_valid, busy}, 3'b000);
        check("reset_result", result, 64'd0);
`ifdef MAC_DOT_SEQ_OVF_EN
        check("reset_ovf", ovf, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run($sformatf("vec%0d", i), vecs[i].len, vecs[i].a, vecs[i].b,
                vecs[i].stall, vecs[i].exp, 0);
        end

        // Result backpressure: result and valid hold while busy stays high.
        start = 1'b1;
        len   = LEN_W'(1);
        tick();
        start = 1'b0;
        send_beat(16'd3, 16'd5);
        wait_result(cyc);
        bp_ok = 1'b1;
        repeat (5) begin
            tick();
            if (!result_valid || result != 36'd15 || !busy) bp_ok = 1'b0;
        end
        check("backpressure_hold", bp_ok, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
        check("result_retained_idle", result, 64'd15);

        // Mid-stream reset after 2 of 3 beats.
        start = 1'b1;
        len   = LEN_W'(3);
        tick();
        start = 1'b0;
        send_beat(16'd1, 16'd2);
        send_beat(16'd5, 16'd2);
        #2 reset = 1'b1;
        #1;
        check("midreset_mac", {mac_reset, mac_a, mac_b}, {1'b1, 32'd0});
        check("midreset_handshake", {in_ready, result_valid, busy}, 3'b000);
        check("midreset_result", result, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        run("after_reset", 1, mk(3, 0, 0, 0), mk(4, 0, 0, 0), 0, 36'd12, 0);

        // Start during STREAM must be ignored and not queued.
        start = 1'b1;
        len   = LEN_W'(2);
        tick();
        start = 1'b0;
        send_beat(16'd1, 16'd1);
        start = 1'b1;
        len   = LEN_W'(5);
        tick();
        start = 1'b0;
        send_beat(16'd2, 16'd2);
        wait_result(cyc);
        check("busy_start_drain_cycles", cyc, MAC_LAT + 1);
        check("busy_start_result", result, 64'd5);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        repeat (3) tick();
        check("start_not_queued", {busy, result_valid}, 2'b00);
        run("after_ignored", 1, mk(7, 0, 0, 0), mk(7, 0, 0, 0), 0, 36'd49, 0);

`ifdef MAC_DOT_SEQ_OVF_EN
        run("ovf16", 16, mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
            mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0, 36'd68717379600, 0);
        run("ovf17", 17, mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
            mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 0, 36'd4292739089, 1);
        run("ovf_zero_len", 0, mk(0, 0, 0, 0), mk(0, 0, 0, 0), 0, 36'd0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
